// File: rtl/alarm_led_pkg.sv
// alarm_led_pkg: shared state encoding and LED pattern constants for the alarm LED block
//   state_t        2-bit FSM state (IDLE=0, RUN=1, ALARM=2, HOLD=3)
//   LED_ALARM_INIT pattern loaded on alarm entry
//   LED_HOLD       pattern shown once the alarm has timed out
package alarm_led_pkg;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_ALARM = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;
    localparam logic [15:0] LED_ALARM_INIT = 16'h0001;
    localparam logic [15:0] LED_HOLD       = 16'hFFFF;
endpackage

// File: rtl/alarm_led_tick_gen.sv
// tick_gen: free-running prescaler producing a one-cycle TICK every TICK_FULL clocks
//   CLK   clock, rising edge
//   RST   asynchronous active-low reset
//   CLR   synchronous restart of the count from 0
//   TICK  high for one cycle while the count sits at TICK_FULL-1
module tick_gen #(
    parameter int TICK_FULL = 25_000_000
) (
    input  logic CLK,
    input  logic RST,
    input  logic CLR,
    output logic TICK
);
    localparam int W = $clog2(TICK_FULL);
    logic [W-1:0] cnt;
    assign TICK = cnt == W'(TICK_FULL - 1);
    always_ff @(posedge CLK or negedge RST)
        if (!RST) cnt <= '0;
        else cnt <= (CLR || TICK) ? '0 : cnt + W'(1);
endmodule

// File: rtl/alarm_led.sv
// alarm_led: countdown alarm indicator driving a 16-bit LED bar and display blanking
//   CLK    clock, rising edge
//   RST    asynchronous active-low reset
//   BUSY   countdown running (level)
//   DONE   countdown reached zero (level)
//   ACK    one-cycle acknowledge pulse from the button filter
//   LED    registered LED pattern
//   ALARM  registered, high in ALARM and HOLD
//   BLANK  registered, high blanks the 7-segment display
module alarm_led
    import alarm_led_pkg::*;
#(
    parameter int TICK_FULL   = 25_000_000,
    parameter int ALARM_STEPS = 40
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        BUSY,
    input  logic        DONE,
    input  logic        ACK,
    output logic [15:0] LED,
    output logic        ALARM,
    output logic        BLANK
);
    state_t      state, state_n;
    logic        done_q, busy_q;
    logic        done_rise, busy_rise, busy_fall;
    logic        tick, entry;
    logic [7:0]  step, step_n;
    logic [15:0] led_n;
    logic        alarm_n, blank_n;

    assign done_rise = DONE & ~done_q;
    assign busy_rise = BUSY & ~busy_q;
    assign busy_fall = ~BUSY & busy_q;
    // any state change restarts the prescaler so every state sees full-length steps
    assign entry     = state_n != state;

    tick_gen #(.TICK_FULL(TICK_FULL)) u_tick (
        .CLK  (CLK),
        .RST  (RST),
        .CLR  (entry),
        .TICK (tick)
    );

    always_ff @(posedge CLK or negedge RST)
        if (!RST) begin
            state  <= ST_IDLE;
            done_q <= 1'b0;
            busy_q <= 1'b0;
        end else begin
            state  <= state_n;
            done_q <= DONE;
            busy_q <= BUSY;
        end

    always_comb begin
        state_n = state;
        case (state)
            ST_IDLE:  state_n = busy_rise ? ST_RUN : ST_IDLE;
            ST_RUN:   state_n = done_rise ? ST_ALARM : busy_fall ? ST_IDLE : ST_RUN;
            ST_ALARM: state_n = ACK ? ST_IDLE
                              : (tick && step == 8'(ALARM_STEPS - 1)) ? ST_HOLD : ST_ALARM;
            ST_HOLD:  state_n = busy_rise ? ST_RUN : ACK ? ST_IDLE : ST_HOLD;
            default:  state_n = ST_IDLE;
        endcase
    end

    // next register values are derived from the state being entered, so every
    // output lands exactly one cycle after the edge or tick that caused it
    always_comb begin
        led_n   = LED;
        blank_n = BLANK;
        step_n  = step;
        alarm_n = state_n == ST_ALARM || state_n == ST_HOLD;
        case (state_n)
            ST_RUN: begin
                led_n   = entry ? 16'h0000 : {15'b0, LED[0] ^ tick};
                blank_n = 1'b0;
            end
            ST_ALARM: begin
                led_n   = entry ? LED_ALARM_INIT : tick ? {LED[14:0], LED[15]} : LED;
                blank_n = entry ? 1'b1 : BLANK ^ tick;
                step_n  = entry ? 8'd0 : step + {7'b0, tick};
            end
            ST_HOLD: begin
                led_n   = LED_HOLD;
                blank_n = 1'b0;
            end
            default: begin
                led_n   = 16'h0000;
                blank_n = 1'b0;
                step_n  = 8'd0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST)
        if (!RST) begin
            LED   <= 16'h0000;
            ALARM <= 1'b0;
            BLANK <= 1'b0;
            step  <= 8'd0;
        end else begin
            LED   <= led_n;
            ALARM <= alarm_n;
            BLANK <= blank_n;
            step  <= step_n;
        end
endmodule

// File: tb/tb_alarm_led.sv
// tb_alarm_led: directed stimulus with a per-cycle behavioural model and literal spot checks
module tb_alarm_led;
    localparam int T = 4;
    localparam int S = 3;
    localparam int M_IDLE = 0, M_RUN = 1, M_ALARM = 2, M_HOLD = 3;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        BUSY = 1'b0, DONE = 1'b0, ACK = 1'b0;
    logic [15:0] LED;
    logic        ALARM, BLANK;

    int n_checks = 0;
    int n_pass = 0;

    int   m_mode = M_IDLE;
    int   m_age = 0;
    logic m_dq = 1'b0, m_bq = 1'b0;

    alarm_led #(.TICK_FULL(T), .ALARM_STEPS(S)) dut (
        .CLK(CLK), .RST(RST), .BUSY(BUSY), .DONE(DONE), .ACK(ACK),
        .LED(LED), .ALARM(ALARM), .BLANK(BLANK)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    // model: a mode plus the number of cycles spent in it; patterns follow from age / T
    always @(posedge CLK or negedge RST) begin : model
        int nm;
        logic dr, br, bf, tk;
        if (!RST) begin
            m_mode <= M_IDLE;
            m_age  <= 0;
            m_dq   <= 1'b0;
            m_bq   <= 1'b0;
        end else begin
            dr = DONE && !m_dq;
            br = BUSY && !m_bq;
            bf = !BUSY && m_bq;
            tk = (m_age % T) == T - 1;
            nm = m_mode;
            if (m_mode == M_IDLE && br) nm = M_RUN;
            else if (m_mode == M_RUN) nm = dr ? M_ALARM : bf ? M_IDLE : M_RUN;
            else if (m_mode == M_ALARM) nm = ACK ? M_IDLE : (tk && (m_age + 1) / T == S) ? M_HOLD : M_ALARM;
            else if (m_mode == M_HOLD) nm = br ? M_RUN : ACK ? M_IDLE : M_HOLD;
            m_age  <= (nm == m_mode) ? m_age + 1 : 0;
            m_mode <= nm;
            m_dq   <= DONE;
            m_bq   <= BUSY;
        end
    end

    function automatic logic [15:0] exp_led(int mode, int age);
        case (mode)
            M_RUN:   return 16'((age / T) % 2);
            M_ALARM: return 16'(1) << ((age / T) % 16);
            M_HOLD:  return 16'hFFFF;
            default: return 16'h0000;
        endcase
    endfunction

    always @(posedge CLK) begin
        #1;
        check("model_led", LED, exp_led(m_mode, m_age));
        check("model_alarm", {15'b0, ALARM}, {15'b0, m_mode == M_ALARM || m_mode == M_HOLD});
        check("model_blank", {15'b0, BLANK}, {15'b0, m_mode == M_ALARM && ((m_age / T) % 2 == 0)});
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic outs(input string name, input logic [15:0] l, input logic a, input logic b);
        check({name, "_led"}, LED, l);
        check({name, "_alarm"}, {15'b0, ALARM}, {15'b0, a});
        check({name, "_blank"}, {15'b0, BLANK}, {15'b0, b});
    endtask

    initial begin
        #1 RST = 1'b0;
        cyc(2);
        outs("reset", 16'h0000, 1'b0, 1'b0);
        RST = 1'b1;
        cyc(1);
        BUSY = 1'b1;
        cyc(1);
        outs("run_entry", 16'h0000, 1'b0, 1'b0);
        cyc(4);
        check("hb_on", LED, 16'h0001);
        cyc(4);
        check("hb_off", LED, 16'h0000);
        DONE = 1'b1;
        cyc(1);
        outs("alarm_entry", 16'h0001, 1'b1, 1'b1);
        cyc(4);
        outs("alarm_step1", 16'h0002, 1'b1, 1'b0);
        cyc(4);
        outs("alarm_step2", 16'h0004, 1'b1, 1'b1);
        cyc(4);
        outs("hold", 16'hFFFF, 1'b1, 1'b0);
        ACK = 1'b1;
        cyc(1);
        ACK = 1'b0;
        outs("hold_ack", 16'h0000, 1'b0, 1'b0);
        cyc(3);
        check("idle_stays", {15'b0, ALARM}, 16'h0000);

        BUSY = 1'b0; DONE = 1'b0;
        cyc(2);
        BUSY = 1'b1;
        cyc(1);
        DONE = 1'b1;
        cyc(1);
        check("alarm2_entry", LED, 16'h0001);
        cyc(11);
        ACK = 1'b1;
        cyc(1);
        ACK = 1'b0;
        outs("ack_beats_timeout", 16'h0000, 1'b0, 1'b0);
        cyc(2);

        BUSY = 1'b0; DONE = 1'b0;
        cyc(2);
        BUSY = 1'b1;
        cyc(1);
        DONE = 1'b1;
        cyc(3);
        check("alarm3_on", {15'b0, ALARM}, 16'h0001);
        #2 RST = 1'b0;
        #1;
        outs("async_reset", 16'h0000, 1'b0, 1'b0);
        DONE = 1'b0;
        cyc(2);
        RST = 1'b1;
        cyc(1);
        check("post_reset_run", LED, 16'h0000);
        cyc(4);
        check("post_reset_hb", LED, 16'h0001);

        DONE = 1'b1;
        cyc(1);
        BUSY = 1'b0; DONE = 1'b0;
        cyc(3);
        BUSY = 1'b1;
        cyc(2);
        check("busy_rise_ignored", {15'b0, ALARM}, 16'h0001);
        BUSY = 1'b0;
        cyc(7);
        outs("hold2", 16'hFFFF, 1'b1, 1'b0);
        ACK = 1'b1; BUSY = 1'b1;
        cyc(1);
        ACK = 1'b0;
        outs("ack_and_busy", 16'h0000, 1'b0, 1'b0);
        cyc(4);
        check("rerun_hb", LED, 16'h0001);
        BUSY = 1'b0;
        cyc(1);
        outs("busy_fall_idle", 16'h0000, 1'b0, 1'b0);
        cyc(4);
        check("idle_no_hb", LED, 16'h0000);
        ACK = 1'b1;
        cyc(1);
        ACK = 1'b0;
        BUSY = 1'b1;
        cyc(1);
        ACK = 1'b1; DONE = 1'b1;
        cyc(1);
        ACK = 1'b0;
        outs("done_with_ack", 16'h0001, 1'b1, 1'b1);
        cyc(3);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule
